// File: rtl/rs_ino_status.sv
// Slot-status tracker for an in-order reservation station: busy/ready/spectag
// bookkeeping across allocation, result-bus wakeup, issue and branch resolution.
module rs_ino_status #(
   parameter int ENTSEL      = 2,
   parameter int ENTNUM      = 4,
   parameter int RRF_SEL     = 6,
   parameter int SPECTAG_LEN = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ENTSEL-1:0]        allocptr,
   input  logic                     we1,
   input  logic                     we2,
   input  logic [SPECTAG_LEN-1:0]   wspectag1,
   input  logic [SPECTAG_LEN-1:0]   wspectag2,
   input  logic [2*RRF_SEL-1:0]     wsrctag1,
   input  logic [2*RRF_SEL-1:0]     wsrctag2,
   input  logic [1:0]               wsrcrdy1,
   input  logic [1:0]               wsrcrdy2,
   input  logic [ENTSEL-1:0]        issueptr,
   input  logic                     issue,
   input  logic [1:0]               wk_valid,
   input  logic [2*RRF_SEL-1:0]     wk_tag,
   input  logic                     prmiss,
   input  logic                     prsuccess,
   input  logic [SPECTAG_LEN-1:0]   prtag,
   output logic [ENTNUM-1:0]        busyvec,
   output logic [ENTNUM-1:0]        readyvec,
   output logic [ENTNUM-1:0]        prbusyvec_next,
   output logic [SPECTAG_LEN-1:0]   issue_spectag
);

   typedef logic [SPECTAG_LEN-1:0] spectag_t;
   typedef logic [RRF_SEL-1:0]     rtag_t;

   logic [ENTNUM-1:0] busy_q, busy_d;
   logic [ENTNUM-1:0] rdy1_q, rdy1_d;
   logic [ENTNUM-1:0] rdy2_q, rdy2_d;
   spectag_t          spectag_q [ENTNUM];
   spectag_t          spectag_d [ENTNUM];
   rtag_t             tag1_q    [ENTNUM];
   rtag_t             tag1_d    [ENTNUM];
   rtag_t             tag2_q    [ENTNUM];
   rtag_t             tag2_d    [ENTNUM];

   logic [ENTSEL-1:0] alloc2_idx;
   spectag_t          commit_mask;

   // True when either result bus broadcasts the given tag this cycle.
   function automatic logic wk_hit(input rtag_t tag, input logic [1:0] valid,
                                   input logic [2*RRF_SEL-1:0] bus_tags);
      return (valid[0] && (bus_tags[RRF_SEL-1:0] == tag)) ||
             (valid[1] && (bus_tags[2*RRF_SEL-1:RRF_SEL] == tag));
   endfunction

   // ENTSEL-bit add gives the modulo-ENTNUM wrap for the second op.
   assign alloc2_idx  = allocptr + ENTSEL'(1);
   assign commit_mask = (prsuccess && !prmiss) ? prtag : '0;

   always_comb begin
      // NOTE: every next-state variable takes its hold value first so no path leaves it unassigned (no latches).
      busy_d = busy_q;
      rdy1_d = rdy1_q;
      rdy2_d = rdy2_q;
      for (int i = 0; i < ENTNUM; i++) begin
         spectag_d[i] = spectag_q[i] & ~commit_mask;
         tag1_d[i]    = tag1_q[i];
         tag2_d[i]    = tag2_q[i];
      end

      for (int i = 0; i < ENTNUM; i++) begin
         if (busy_q[i]) begin
            if (wk_hit(tag1_q[i], wk_valid, wk_tag)) rdy1_d[i] = 1'b1;
            if (wk_hit(tag2_q[i], wk_valid, wk_tag)) rdy2_d[i] = 1'b1;
         end
         if (prmiss && (|(spectag_q[i] & prtag))) busy_d[i] = 1'b0;
         if (issue && (issueptr == ENTSEL'(i)))  busy_d[i] = 1'b0;

         // Writes come last so a slot freed and refilled in one cycle ends busy.
         if (!prmiss && we1 && (allocptr == ENTSEL'(i))) begin
            busy_d[i]    = 1'b1;
            spectag_d[i] = wspectag1 & ~commit_mask;
            tag1_d[i]    = wsrctag1[RRF_SEL-1:0];
            tag2_d[i]    = wsrctag1[2*RRF_SEL-1:RRF_SEL];
            rdy1_d[i]    = wsrcrdy1[0] | wk_hit(wsrctag1[RRF_SEL-1:0], wk_valid, wk_tag);
            rdy2_d[i]    = wsrcrdy1[1] | wk_hit(wsrctag1[2*RRF_SEL-1:RRF_SEL], wk_valid, wk_tag);
         end else if (!prmiss && we2 && (alloc2_idx == ENTSEL'(i))) begin
            busy_d[i]    = 1'b1;
            spectag_d[i] = wspectag2 & ~commit_mask;
            tag1_d[i]    = wsrctag2[RRF_SEL-1:0];
            tag2_d[i]    = wsrctag2[2*RRF_SEL-1:RRF_SEL];
            rdy1_d[i]    = wsrcrdy2[0] | wk_hit(wsrctag2[RRF_SEL-1:0], wk_valid, wk_tag);
            rdy2_d[i]    = wsrcrdy2[1] | wk_hit(wsrctag2[2*RRF_SEL-1:RRF_SEL], wk_valid, wk_tag);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: the per-slot arrays are reset too, because issue_spectag must read zero after reset.
      if (!reset) begin
         busy_q <= '0;
         rdy1_q <= '0;
         rdy2_q <= '0;
         for (int i = 0; i < ENTNUM; i++) begin
            spectag_q[i] <= '0;
            tag1_q[i]    <= '0;
            tag2_q[i]    <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep every slot register sampling the pre-edge state.
         busy_q <= busy_d;
         rdy1_q <= rdy1_d;
         rdy2_q <= rdy2_d;
         for (int i = 0; i < ENTNUM; i++) begin
            spectag_q[i] <= spectag_d[i];
            tag1_q[i]    <= tag1_d[i];
            tag2_q[i]    <= tag2_d[i];
         end
      end
   end

   assign busyvec       = busy_q;
   assign readyvec      = busy_q & rdy1_q & rdy2_q;
   assign issue_spectag = spectag_q[issueptr];

   // Post-resolution view for the pointer logic; deliberately ignores this cycle's writes.
   always_comb begin
      prbusyvec_next = '0;
      for (int i = 0; i < ENTNUM; i++) begin
         prbusyvec_next[i] = busy_q[i] &
                             ~(issue && (issueptr == ENTSEL'(i))) &
                             ~(|(spectag_q[i] & prtag));
      end
   end

endmodule

// File: tb/tb_rs_ino_status.sv
// Randomised and directed bench for rs_ino_status against a slot-level reference model.
module tb_rs_ino_status;

   localparam int ENTSEL = 2, ENTNUM = 4, RRF_SEL = 6, SPECTAG_LEN = 5;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [ENTSEL-1:0]      allocptr;
   logic                   we1, we2;
   logic [SPECTAG_LEN-1:0] wspectag1, wspectag2;
   logic [2*RRF_SEL-1:0]   wsrctag1, wsrctag2;
   logic [1:0]             wsrcrdy1, wsrcrdy2;
   logic [ENTSEL-1:0]      issueptr;
   logic                   issue;
   logic [1:0]             wk_valid;
   logic [2*RRF_SEL-1:0]   wk_tag;
   logic                   prmiss, prsuccess;
   logic [SPECTAG_LEN-1:0] prtag;
   logic [ENTNUM-1:0]      busyvec, readyvec, prbusyvec_next;
   logic [SPECTAG_LEN-1:0] issue_spectag;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic                   busy;
      logic [SPECTAG_LEN-1:0] spec;
      logic                   r1, r2;
      logic [RRF_SEL-1:0]     t1, t2;
   } slot_t;

   slot_t mdl [ENTNUM];

   rs_ino_status #(.ENTSEL(ENTSEL), .ENTNUM(ENTNUM), .RRF_SEL(RRF_SEL),
                   .SPECTAG_LEN(SPECTAG_LEN)) dut (
      .clk(clk), .reset(reset), .allocptr(allocptr), .we1(we1), .we2(we2),
      .wspectag1(wspectag1), .wspectag2(wspectag2),
      .wsrctag1(wsrctag1), .wsrctag2(wsrctag2),
      .wsrcrdy1(wsrcrdy1), .wsrcrdy2(wsrcrdy2),
      .issueptr(issueptr), .issue(issue), .wk_valid(wk_valid), .wk_tag(wk_tag),
      .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
      .busyvec(busyvec), .readyvec(readyvec), .prbusyvec_next(prbusyvec_next),
      .issue_spectag(issue_spectag)
   );

   always #5 clk = ~clk;

   task automatic idle();
      allocptr = '0; we1 = 0; we2 = 0; wspectag1 = '0; wspectag2 = '0;
      wsrctag1 = '0; wsrctag2 = '0; wsrcrdy1 = '0; wsrcrdy2 = '0;
      issueptr = '0; issue = 0; wk_valid = '0; wk_tag = '0;
      prmiss = 0; prsuccess = 0; prtag = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < ENTNUM; i++) mdl[i] = '{1'b0, '0, 1'b0, 1'b0, '0, '0};
   endtask

   function automatic logic bus_hit(input logic [RRF_SEL-1:0] t);
      return (wk_valid[0] && wk_tag[RRF_SEL-1:0] == t) ||
             (wk_valid[1] && wk_tag[2*RRF_SEL-1:RRF_SEL] == t);
   endfunction

   function automatic slot_t new_op(input logic [SPECTAG_LEN-1:0] spec,
                                    input logic [2*RRF_SEL-1:0] tags, input logic [1:0] rdy);
      slot_t s;
      s.busy = 1'b1;
      s.spec = prsuccess ? (spec & ~prtag) : spec;
      s.t1   = tags[RRF_SEL-1:0];
      s.t2   = tags[2*RRF_SEL-1:RRF_SEL];
      s.r1   = rdy[0] | bus_hit(s.t1);
      s.r2   = rdy[1] | bus_hit(s.t2);
      return s;
   endfunction

   // Apply one clock of the station's rules to the model using the current inputs.
   task automatic model_step();
      slot_t nx [ENTNUM];
      for (int i = 0; i < ENTNUM; i++) begin
         nx[i] = mdl[i];
         if (mdl[i].busy && bus_hit(mdl[i].t1)) nx[i].r1 = 1'b1;
         if (mdl[i].busy && bus_hit(mdl[i].t2)) nx[i].r2 = 1'b1;
         if (prsuccess && !prmiss) nx[i].spec = mdl[i].spec & ~prtag;
         if (prmiss && (mdl[i].spec & prtag) != 0) nx[i].busy = 1'b0;
      end
      if (issue) nx[issueptr].busy = 1'b0;
      if (!prmiss) begin
         if (we1) nx[allocptr] = new_op(wspectag1, wsrctag1, wsrcrdy1);
         if (we2) nx[(int'(allocptr) + 1) % ENTNUM] = new_op(wspectag2, wsrctag2, wsrcrdy2);
      end
      for (int i = 0; i < ENTNUM; i++) mdl[i] = nx[i];
   endtask

   function automatic logic [ENTNUM-1:0] exp_busy();
      logic [ENTNUM-1:0] v = '0;
      for (int i = 0; i < ENTNUM; i++) v[i] = mdl[i].busy;
      return v;
   endfunction

   function automatic logic [ENTNUM-1:0] exp_ready();
      logic [ENTNUM-1:0] v = '0;
      for (int i = 0; i < ENTNUM; i++) v[i] = mdl[i].busy && mdl[i].r1 && mdl[i].r2;
      return v;
   endfunction

   function automatic logic [ENTNUM-1:0] exp_prbusy();
      logic [ENTNUM-1:0] v = '0;
      for (int i = 0; i < ENTNUM; i++)
         v[i] = mdl[i].busy && !(issue && int'(issueptr) == i) && ((mdl[i].spec & prtag) == 0);
      return v;
   endfunction

   // Called just after a negedge with inputs applied; returns just after the next negedge.
   task automatic step(input string name);
      logic [ENTNUM-1:0] eb, er;
      #1;
      checks++;
      if (prbusyvec_next !== exp_prbusy()) begin
         failures++;
         $display("FAIL %s prbusyvec_next got=%b exp=%b", name, prbusyvec_next, exp_prbusy());
      end
      checks++;
      if (issue_spectag !== mdl[issueptr].spec) begin
         failures++;
         $display("FAIL %s issue_spectag got=%b exp=%b", name, issue_spectag, mdl[issueptr].spec);
      end
      @(posedge clk);
      model_step();
      #1;
      eb = exp_busy();
      er = exp_ready();
      checks++;
      if (busyvec !== eb) begin
         failures++;
         $display("FAIL %s busyvec got=%b exp=%b", name, busyvec, eb);
      end
      checks++;
      if (readyvec !== er) begin
         failures++;
         $display("FAIL %s readyvec got=%b exp=%b", name, readyvec, er);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic expect_vec(input string name, input logic [ENTNUM-1:0] got,
                             input logic [ENTNUM-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      expect_vec("reset_busyvec", busyvec, '0);
      expect_vec("reset_readyvec", readyvec, '0);
      expect_vec("reset_prbusyvec_next", prbusyvec_next, '0);
      checks++;
      if (issue_spectag !== '0) begin
         failures++;
         $display("FAIL reset_issue_spectag got=%b exp=%b", issue_spectag, 5'b0);
      end
      step("reset_idle");
   endtask

   task automatic test_alloc_wrap();
      do_reset();
      allocptr = 2'd3; we1 = 1; we2 = 1;
      wsrcrdy1 = 2'b11; wsrcrdy2 = 2'b11;
      step("alloc_wrap");
      expect_vec("alloc_wrap_busyvec", busyvec, 4'b1001);
      expect_vec("alloc_wrap_readyvec", readyvec, 4'b1001);
   endtask

   task automatic test_write_wakeup();
      do_reset();
      allocptr = 2'd0; we1 = 1;
      wsrctag1 = {6'h00, 6'h05}; wsrcrdy1 = 2'b10;
      wk_valid = 2'b10; wk_tag = {6'h05, 6'h3F};
      step("write_wakeup");
      expect_vec("write_wakeup_readyvec", readyvec, 4'b0001);
   endtask

   task automatic test_resident_wakeup();
      do_reset();
      allocptr = 2'd2; we1 = 1; wsrctag1 = {6'h0B, 6'h0A}; wsrcrdy1 = 2'b00;
      step("resident_alloc");
      wk_valid = 2'b01; wk_tag = {6'h00, 6'h0A};
      step("resident_bus0");
      expect_vec("resident_half_readyvec", readyvec, 4'b0000);
      step("resident_gap");
      wk_valid = 2'b10; wk_tag = {6'h0B, 6'h00};
      step("resident_bus1");
      expect_vec("resident_full_readyvec", readyvec, 4'b0100);
   endtask

   task automatic test_mispredict();
      do_reset();
      allocptr = 2'd0; we1 = 1; we2 = 1; wspectag1 = 5'b00001; wspectag2 = 5'b00010;
      step("mp_alloc01");
      allocptr = 2'd2; we1 = 1; we2 = 1; wspectag1 = 5'b00010; wspectag2 = 5'b00000;
      step("mp_alloc23");
      prmiss = 1; prtag = 5'b00010; issue = 1; issueptr = 2'd0;
      allocptr = 2'd1; we1 = 1;
      #1;
      expect_vec("mp_prbusyvec_next", prbusyvec_next, 4'b1000);
      step("mp_kill");
      expect_vec("mp_busyvec", busyvec, 4'b1000);
   endtask

   task automatic test_commit();
      do_reset();
      allocptr = 2'd1; we1 = 1; we2 = 1; wspectag1 = 5'b00110; wspectag2 = 5'b01000;
      step("commit_alloc");
      prsuccess = 1; prtag = 5'b00100;
      step("commit_success");
      issueptr = 2'd1;
      #1;
      checks++;
      if (issue_spectag !== 5'b00010) begin
         failures++;
         $display("FAIL commit_spectag got=%b exp=%b", issue_spectag, 5'b00010);
      end
      prmiss = 1; prtag = 5'b00100;
      step("commit_survive");
      expect_vec("commit_survive_busyvec", busyvec, 4'b0110);
      prmiss = 1; prsuccess = 1; prtag = 5'b01000;
      step("commit_miss_wins");
      expect_vec("commit_miss_wins_busyvec", busyvec, 4'b0010);
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic f1, f2;
         int   a2;
         idle();
         wk_valid  = 2'($urandom);
         wk_tag    = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
         issue     = 1'($urandom);
         issueptr  = 2'($urandom);
         prmiss    = ($urandom % 16) == 0;
         prsuccess = ($urandom % 8) == 0;
         prtag     = 5'(1) << $urandom_range(0, 4);
         allocptr  = 2'($urandom);
         a2        = (int'(allocptr) + 1) % ENTNUM;
         f1 = !mdl[allocptr].busy || (issue && issueptr == allocptr);
         f2 = !mdl[a2].busy || (issue && int'(issueptr) == a2);
         we1 = f1 && ($urandom % 4 != 0);
         we2 = we1 && f2 && ($urandom % 2 == 0);
         wspectag1 = 5'($urandom); wspectag2 = 5'($urandom);
         wsrctag1  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
         wsrctag2  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
         wsrcrdy1  = 2'($urandom); wsrcrdy2 = 2'($urandom);
         step("random");
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      allocptr = 2'd0; we1 = 1; we2 = 1; wsrcrdy1 = 2'b11; wsrcrdy2 = 2'b11;
      step("async_alloc");
      expect_vec("async_pre_busyvec", busyvec, 4'b0011);
      #2;
      reset = 1'b0;
      #1;
      expect_vec("async_busyvec", busyvec, 4'b0000);
      expect_vec("async_readyvec", readyvec, 4'b0000);
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      step("async_after_release");
      expect_vec("async_after_busyvec", busyvec, 4'b0000);
   endtask

   initial begin
      idle();
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_alloc_wrap();
      test_write_wakeup();
      test_resident_wakeup();
      test_mispredict();
      test_commit();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
